// File: rtl/ddr2_aref.sv
// ddr2_aref: DDR2 auto-refresh scheduler; issues precharge-all then AUTO REFRESH on grant.
// Optional macro AREF_POSTPONE_EN: up to 8 postponed refreshes and a registered aref_urgent flag.
module ddr2_aref #(
   parameter int BA_BITS   = 3,
   parameter int ADDR_BITS = 14,
   parameter int tCK       = 5,
   parameter int tREFI     = 7800,
   parameter int tRP       = 20,
   parameter int tRFC      = 130
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init_end,
   input  logic                 aref_en,
   output logic                 aref_req,
   output logic [3:0]           aref_cmd,
   output logic [BA_BITS-1:0]   aref_ba,
   output logic [ADDR_BITS-1:0] aref_addr,
   output logic                 aref_end,
   output logic                 aref_urgent
);

   localparam int REFI_CYC = tREFI / tCK;
   localparam int RP_CYC   = tRP / tCK;
   localparam int RFC_CYC  = tRFC / tCK;
   localparam int CNT_W    = $clog2(REFI_CYC);
   localparam int WAIT_W   = $clog2(RFC_CYC);
`ifdef AREF_POSTPONE_EN
   localparam int PEND_W   = 4;
   localparam int PEND_MAX = 8;
`else
   localparam int PEND_W   = 1;
   localparam int PEND_MAX = 1;
`endif

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRE      = 3'd1;
   localparam logic [2:0] S_WAIT_RP  = 3'd2;
   localparam logic [2:0] S_AREF     = 3'd3;
   localparam logic [2:0] S_WAIT_RFC = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PEND_W-1:0]    pend_q, pend_d;
   logic [2:0]           state_q, state_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic [3:0]           cmd_q, cmd_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 end_q, end_d;
   logic                 urgent_q, urgent_d;
   logic                 tick;
   logic                 done;

   assign tick = (cnt_q == CNT_W'(REFI_CYC - 1));
   assign done = (state_q == S_DONE);

   always_comb begin
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      state_d = state_q;
      wait_d  = wait_q;
      if (!init_end) begin
         cnt_d   = '0;
         pend_d  = '0;
         state_d = S_IDLE;
         wait_d  = '0;
      end else begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         // A tick coinciding with the DONE decrement leaves pending unchanged.
         if (tick && !done) begin
            if (pend_q != PEND_W'(PEND_MAX)) pend_d = pend_q + 1'b1;
         end else if (!tick && done) begin
            pend_d = pend_q - 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if ((pend_q != '0) && aref_en) state_d = S_PRE;
            end
            S_PRE: begin
               state_d = S_WAIT_RP;
               wait_d  = WAIT_W'(RP_CYC - 2);
            end
            S_WAIT_RP: begin
               if (wait_q == '0) state_d = S_AREF;
               else              wait_d  = wait_q - 1'b1;
            end
            S_AREF: begin
               state_d = S_WAIT_RFC;
               wait_d  = WAIT_W'(RFC_CYC - 2);
            end
            S_WAIT_RFC: begin
               if (wait_q == '0) state_d = S_DONE;
               else              wait_d  = wait_q - 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Command outputs are registered from the state being entered, so they line up with it.
   always_comb begin
      cmd_d  = CMD_NOP;
      addr_d = '0;
      case (state_d)
         S_PRE: begin
            cmd_d      = CMD_PRE;
            addr_d[10] = 1'b1;
         end
         S_AREF:  cmd_d = CMD_AREF;
         default: cmd_d = CMD_NOP;
      endcase
      end_d = (state_d == S_DONE);
`ifdef AREF_POSTPONE_EN
      urgent_d = (pend_d >= PEND_W'(7));
`else
      urgent_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         pend_q   <= '0;
         state_q  <= S_IDLE;
         wait_q   <= '0;
         cmd_q    <= CMD_NOP;
         addr_q   <= '0;
         end_q    <= 1'b0;
         urgent_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         state_q  <= state_d;
         wait_q   <= wait_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         end_q    <= end_d;
         urgent_q <= urgent_d;
      end
   end

   assign aref_req    = (state_q == S_IDLE) && (pend_q != '0);
   assign aref_cmd    = cmd_q;
   assign aref_ba     = '0;
   assign aref_addr   = addr_q;
   assign aref_end    = end_q;
   assign aref_urgent = urgent_q;

endmodule

// File: tb/tb_ddr2_aref.sv
// Bench for ddr2_aref: cycle-offset reference model checked every cycle, plus
// table-driven sequence timing and directed corner cases.
module tb_ddr2_aref;
   localparam int REFI    = 1560;
   localparam int RP      = 4;
   localparam int RFC     = 26;
   localparam int END_OFF = 1 + RP + RFC;
`ifdef AREF_POSTPONE_EN
   localparam int PMAX     = 8;
   localparam bit POSTPONE = 1'b1;
`else
   localparam int PMAX     = 1;
   localparam bit POSTPONE = 1'b0;
`endif
   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] PRE  = 4'b0010;
   localparam logic [3:0] AREF = 4'b0001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_end = 1'b0;
   logic        aref_en = 1'b0;
   logic        aref_req;
   logic [3:0]  aref_cmd;
   logic [2:0]  aref_ba;
   logic [13:0] aref_addr;
   logic        aref_end;
   logic        aref_urgent;

   int n_cmp = 0;
   int n_bad = 0;

   ddr2_aref dut (
      .clk(clk), .rst_n(rst_n), .init_end(init_end), .aref_en(aref_en),
      .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_ba(aref_ba),
      .aref_addr(aref_addr), .aref_end(aref_end), .aref_urgent(aref_urgent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: m_cyc = cycles since init_end went high, m_pos = offset
   // into the current refresh sequence (0 when no sequence is running).
   int m_cyc = 0;
   int m_pend = 0;
   int m_pos = 0;

   function automatic int pend_next(input int p, input bit tick, input bit done);
      int n;
      n = p + int'(tick) - int'(done);
      return (n > PMAX) ? PMAX : n;
   endfunction

   function automatic int pos_next(input int pos, input int pend, input bit en);
      if (pos == 0) return (pend > 0 && en) ? 1 : 0;
      return (pos == END_OFF) ? 0 : pos + 1;
   endfunction

   function automatic logic [3:0] exp_cmd(input int pos);
      if (pos == 1) return PRE;
      if (pos == 1 + RP) return AREF;
      return NOP;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || !init_end) begin
         m_cyc  <= 0;
         m_pend <= 0;
         m_pos  <= 0;
      end else begin
         m_cyc  <= m_cyc + 1;
         m_pend <= pend_next(m_pend, (m_cyc % REFI) == REFI - 1, m_pos == END_OFF);
         m_pos  <= pos_next(m_pos, m_pend, aref_en);
      end
   end

   always @(negedge clk) begin
      chk("mon_req", aref_req, (m_pos == 0) && (m_pend > 0));
      chk("mon_cmd", aref_cmd, exp_cmd(m_pos));
      chk("mon_addr", aref_addr, (m_pos == 1) ? 32'h400 : 32'h0);
      chk("mon_ba", aref_ba, 0);
      chk("mon_end", aref_end, m_pos == END_OFF);
      chk("mon_urgent", aref_urgent, POSTPONE && (m_pend >= 7));
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_req(input string name, output int n);
      n = 0;
      while (!aref_req && n < 2000) begin
         cyc(1);
         n++;
      end
      if (!aref_req) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic count_ends(input int len, output int ends);
      ends = 0;
      repeat (len) begin
         cyc(1);
         if (aref_end) ends++;
      end
   endtask

   typedef struct {
      int          off;
      logic [3:0]  cmd;
      logic [13:0] addr;
      logic        endp;
      logic        req;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int n;
      int cur;
      int ends;

      tbl[0] = '{1,  PRE,  14'h400, 1'b0, 1'b0};
      tbl[1] = '{2,  NOP,  14'h000, 1'b0, 1'b0};
      tbl[2] = '{4,  NOP,  14'h000, 1'b0, 1'b0};
      tbl[3] = '{5,  AREF, 14'h000, 1'b0, 1'b0};
      tbl[4] = '{6,  NOP,  14'h000, 1'b0, 1'b0};
      tbl[5] = '{18, NOP,  14'h000, 1'b0, 1'b0};
      tbl[6] = '{30, NOP,  14'h000, 1'b0, 1'b0};
      tbl[7] = '{31, NOP,  14'h000, 1'b1, 1'b0};
      tbl[8] = '{32, NOP,  14'h000, 1'b0, 1'b0};

      // 1: reset, long init hold, first request latency
      cyc(3);
      chk("rst_cmd", aref_cmd, NOP);
      chk("rst_req", aref_req, 0);
      rst_n = 1'b1;
      cyc(5000);
      chk("t1_req_held", aref_req, 0);
      init_end = 1'b1;
      wait_req("t1", n);
      chk("t1_latency", n, REFI);

      // 2: first grant, sequence timing from table
      aref_en = 1'b1;
      cur = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].off - cur);
         cur = tbl[i].off;
         if (cur == 1) aref_en = 1'b0;
         chk($sformatf("t2_cmd_T%0d", cur), aref_cmd, tbl[i].cmd);
         chk($sformatf("t2_addr_T%0d", cur), aref_addr, tbl[i].addr);
         chk($sformatf("t2_end_T%0d", cur), aref_end, tbl[i].endp);
         chk($sformatf("t2_req_T%0d", cur), aref_req, tbl[i].req);
      end

      // 3: withhold grant for three intervals
      cyc(3 * REFI);
      chk("t3_urgent", aref_urgent, 0);
      aref_en = 1'b1;
      count_ends(106, ends);
      aref_en = 1'b0;
      chk("t3_ends", ends, POSTPONE ? 3 : 1);
      chk("t3_req_after", aref_req, 0);

`ifdef AREF_POSTPONE_EN
      // 4: urgent flag at seven postponed refreshes
      cyc(7 * REFI);
      chk("t4_urgent_rise", aref_urgent, 1);
      aref_en = 1'b1;
      cyc(1);
      aref_en = 1'b0;
      cyc(END_OFF - 1);
      chk("t4_end", aref_end, 1);
      chk("t4_urgent_at_end", aref_urgent, 1);
      cyc(1);
      chk("t4_urgent_fall", aref_urgent, 0);
`endif

      // 5a: grant dropped mid-sequence is ignored
      wait_req("t5a", n);
      aref_en = 1'b1;
      cyc(2);
      aref_en = 1'b0;
      cyc(END_OFF - 2);
      chk("t5a_end", aref_end, 1);
      cyc(1);
      chk("t5a_end_clear", aref_end, 0);

      // 5b: init_end falls at T+10
      wait_req("t5b", n);
      aref_en = 1'b1;
      cyc(1);
      aref_en = 1'b0;
      cyc(9);
      init_end = 1'b0;
      cyc(1);
      chk("t5b_cmd", aref_cmd, NOP);
      chk("t5b_req", aref_req, 0);
      count_ends(25, ends);
      chk("t5b_no_end", ends, 0);
      chk("t5b_req_after", aref_req, 0);

      // 6: asynchronous reset inside WAIT_RFC
      init_end = 1'b1;
      wait_req("t6a", n);
      chk("t6_relatency", n, REFI);
      aref_en = 1'b1;
      cyc(1);
      aref_en = 1'b0;
      cyc(9);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cmd", aref_cmd, NOP);
      chk("t6_rst_addr", aref_addr, 0);
      chk("t6_rst_req", aref_req, 0);
      chk("t6_rst_end", aref_end, 0);
      chk("t6_rst_urgent", aref_urgent, 0);
      cyc(3);
      rst_n = 1'b1;
      wait_req("t6b", n);
      chk("t6_latency", n, REFI);

      // Random grants with occasional init_end drops, checked by the model
      for (int i = 0; i < 3000; i++) begin
         aref_en = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 399) == 0) init_end = ~init_end;
         cyc(1);
      end
      init_end = 1'b1;
      aref_en  = 1'b0;
      cyc(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ddr2_aref.md
Name: ddr2_aref

Overview:
- Auto-refresh scheduler for the DDR2 controller. It sits directly downstream of the power-up initialisation stage and starts only once that stage asserts its init-done level.
- It generates periodic refresh requests for the command arbiter.
- On grant, it drives a precharge-all, then an AUTO REFRESH, onto the shared cmd/ba/addr bus with tRP/tRFC spacing.
- It pulses aref_end when the bus is free again.

Parameters:
- BA_BITS, 3, bank address width.
- ADDR_BITS, 14, row/column address width.
- tCK, 5, clock period in ns.
- tREFI, 7800, average refresh interval in ns; REFI_CYC = tREFI/tCK = 1560.
- tRP, 20, precharge-all to AREF in ns; RP_CYC = tRP/tCK = 4.
- tRFC, 130, AREF to next command in ns; RFC_CYC = tRFC/tCK = 26.

Ports:
- clk  in  1  controller clock
- rst_n  in  1  asynchronous active-low reset
- init_end  in  1  level from init stage; high = DRAM initialised
- aref_en  in  1  grant from arbiter; sampled only in IDLE
- aref_req  out  1  refresh pending and block idle
- aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP 4'b0111, PRE 4'b0010, AREF 4'b0001
- aref_ba  out  BA_BITS  bank address, always 0
- aref_addr  out  ADDR_BITS  address; A10=1 during PRE, else 0
- aref_end  out  1  one-cycle pulse, sequence complete
- aref_urgent  out  1  postponement limit reached (see Optional Feature)

Behaviour:
Clock and reset:
- Single clock. rst_n is asynchronous assert, synchronous release.
- Reset values: aref_cmd=NOP, aref_ba=0, aref_addr=0, aref_req=0, aref_end=0, aref_urgent=0.
- Reset values: interval counter=0, pending=0, state=IDLE.

Interval counter:
- While init_end=0: counter, pending and FSM are synchronously held at reset values. Outputs stay at reset values.
- While init_end=1: counter counts 0..REFI_CYC-1 and wraps to 0.
- Wrap cycle = tick. A tick increments pending, saturating at PEND_MAX (1 without macro).

aref_req:
- aref_req = (state==IDLE) && (pending!=0). Combinational from registers.
- First assertion is exactly REFI_CYC cycles after the first edge with init_end=1.

FSM states, cmd is registered:
- IDLE: cmd=NOP. If aref_req && aref_en at edge T, go to PRE.
- PRE: at T+1, cmd=PRE, addr=A10 set (0x400), for one cycle. Go to WAIT_RP.
- WAIT_RP: cmd=NOP for RP_CYC-1 cycles.
- AREF: cmd=AREF at T+1+RP_CYC, addr=0, for one cycle.
- WAIT_RFC: cmd=NOP for RFC_CYC-1 cycles.
- DONE: one cycle at T+1+RP_CYC+RFC_CYC. aref_end=1, pending decrements, then return to IDLE.

Boundary conditions:
- aref_req drops at T+1 and stays low until IDLE is re-entered.
- If pending is still nonzero on re-entering IDLE, aref_req re-asserts the cycle after DONE.
- aref_en changes outside IDLE are ignored. A started sequence always completes.
- Tick in the same cycle as the DONE decrement: net pending unchanged.
- Tick at saturation: pending stays at PEND_MAX; the refresh is lost. With the macro, aref_urgent flags this condition.
- init_end falling mid-sequence: synchronous abort to IDLE, cmd=NOP next cycle, no aref_end.
- Reset mid-sequence: immediate asynchronous return to reset values.

Optional Feature:
Macro AREF_POSTPONE_EN.
- Defined:
  - PEND_MAX=8, per the DDR2 allowance of up to 8 postponed refreshes. Pending is a 4-bit counter.
  - aref_urgent=1 (registered) whenever pending >= 7. The arbiter must then grant before any new ACT.
  - After a sequence completes, the next request is back-to-back with no dead cycle: aref_req re-asserts in the cycle after DONE.
- Undefined:
  - PEND_MAX=1 and pending is a single flag.
  - aref_urgent is tied 0.

Test Plan:
1. Reset, hold init_end=0 for 5000 cycles, then raise it. aref_req stays 0 throughout, rises exactly 1560 cycles after init_end is sampled high, and aref_cmd stays NOP.
2. Grant on the first aref_req at edge T. Expect:
   - aref_cmd=PRE with aref_addr=0x400 at T+1.
   - aref_cmd=AREF with aref_addr=0 at T+5.
   - aref_end=1 at T+31 only.
   - aref_req low over T+1..T+31.
   - All other cycles NOP.
3. Withhold aref_en for 3 intervals (4680 cycles).
   - Without the macro: pending saturates at 1, aref_urgent=0, and one grant yields one sequence followed by aref_req=0.
   - With the macro: pending=3, three grants yield three sequences, each with aref_end.
4. With the macro, withhold the grant for 7×1560 cycles. aref_urgent rises when pending reaches 7, and falls after the first aref_end brings pending to 6.
5. Deassert aref_en at T+2 of a sequence: the sequence still completes at T+31. Drop init_end at T+10 of another sequence: aref_cmd=NOP from T+11, no aref_end, and aref_req=0.
6. Assert rst_n=0 mid-WAIT_RFC: all outputs are at reset values asynchronously. After release with init_end=1, the first aref_req comes 1560 cycles later.
